uart_tx_serializer: RTL and testbench

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_tx_serializer.sv | 153 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops bytes from an upstream synchronous FIFO and sends
// them as 8N1/8N2 UART frames, LSB first, one bit every baud_div+1 clocks.
// Optional parity state is built only when UART_TX_PARITY_EN is defined.
// state_dbg exposes the FSM state encoding for observation.
//
// FIFO pop handshake: fifo_rd_en is a single-cycle strobe, asserted only
// while fifo_empty=0; the head word fifo_rd_data is consumed on the same
// rising edge where fifo_rd_en=1.
module uart_tx_serializer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_en,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             cfg_stop2,
  input  logic             cfg_par_en,
  input  logic             cfg_par_odd,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_rd_data,
  output logic             fifo_rd_en,
  output logic             txd,
  output logic             tx_busy,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] timer;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             stop2_q;
  logic             bit_end;
  logic             can_pop;
  logic             pop;

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_bit_q;
`else
  logic unused_par_cfg;
  assign unused_par_cfg = cfg_par_en ^ cfg_par_odd;
`endif

  // A bit ends on the cycle its timer has counted down to zero.
  assign bit_end = (timer == '0);
  // Reset gates the pop so no byte is consumed while the block is held.
  assign can_pop = tx_en && !fifo_empty && !reset;

  assign fifo_rd_en = pop;
  assign tx_busy    = (state != IDLE);
  assign state_dbg  = state;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode, line level and pop strobe.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    txd      = 1'b1;
    case (state)
      IDLE: begin
        if (can_pop) begin
          pop      = 1'b1;
          state_nx = START;
        end
      end
      START: begin
        txd = 1'b0;
        if (bit_end) state_nx = DATA;
      end
      DATA: begin
        txd = shreg[0];
        if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_nx = par_en_q ? PARITY : STOP1;
`else
          state_nx = STOP1;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        txd = par_bit_q;
        if (bit_end) state_nx = STOP1;
      end
`endif
      STOP1, STOP2: begin
        if (bit_end) begin
          if (state == STOP1 && stop2_q) begin
            state_nx = STOP2;
          end else if (can_pop) begin
            // Back-to-back frame: pop on the last stop cycle, no idle gap.
            pop      = 1'b1;
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture byte and frame config on pop, run bit timer, shift data.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer   <= '0;
      div_q   <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
      stop2_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else if (pop) begin
      shreg   <= fifo_rd_data;
      div_q   <= baud_div;
      timer   <= baud_div;
      bit_idx <= 3'd0;
      stop2_q <= cfg_stop2;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= cfg_par_en;
      par_bit_q <= (^fifo_rd_data) ^ cfg_par_odd;
`endif
    end else if (state != IDLE) begin
      if (bit_end) begin
        timer <= div_q;
        if (state == DATA) begin
          shreg   <= {1'b0, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        timer <= timer - DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed frames against hand-derived line timing.
module tb_uart_tx_serializer;

  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             tx_en;
  logic [DIV_W-1:0] baud_div;
  logic             cfg_stop2;
  logic             cfg_par_en;
  logic             cfg_par_odd;
  logic             fifo_empty;
  logic [7:0]       fifo_rd_data;
  logic             fifo_rd_en;
  logic             txd;
  logic             tx_busy;
  logic [2:0]       state_dbg;

  logic [7:0] fifo_q[$];
  int         pop_cyc[$];
  bit         txd_log[0:2047];
  bit         busy_log[0:2047];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;

  uart_tx_serializer #(.DIV_W(DIV_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_en        (tx_en),
    .baud_div     (baud_div),
    .cfg_stop2    (cfg_stop2),
    .cfg_par_en   (cfg_par_en),
    .cfg_par_odd  (cfg_par_odd),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .txd          (txd),
    .tx_busy      (tx_busy),
    .state_dbg    (state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_sync();
    fifo_empty   = (fifo_q.size() == 0);
    fifo_rd_data = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_sync();
  endtask

  // One clock: sample outputs at the falling edge, update FIFO model after the rising edge.
  task automatic tick();
    logic popped;
    @(negedge clk);
    txd_log[cyc]  = txd;
    busy_log[cyc] = tx_busy;
    popped = fifo_rd_en;
    if (popped) begin
      pop_cyc.push_back(cyc);
      check("pop_nonempty", {31'd0, fifo_empty}, 32'd0);
    end
    @(posedge clk);
    #1;
    if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_sync();
    cyc++;
  endtask

  task automatic wait_pop(input int n, input int budget, input string tag);
    int t = 0;
    while (pop_cyc.size() < n && t < budget) begin
      tick();
      t++;
    end
    if (pop_cyc.size() < n) check({tag, "_timeout"}, pop_cyc.size(), n);
  endtask

  function automatic int pop_at(input int i);
    return (pop_cyc.size() > i) ? pop_cyc[i] : 0;
  endfunction

  function automatic int busy_count(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) n += int'(busy_log[i]);
    return n;
  endfunction

  // Compare each bit period of a frame whose pop happened on cycle p.
  task automatic check_frame(input string tag, input int p, input logic [7:0] data,
                             input int bp, input bit stop2, input bit has_par, input bit par_bit);
    logic [11:0] seq;
    int          nb;
    logic [31:0] obs, exp;
    seq = '0;
    seq[0] = 1'b0;
    for (int i = 0; i < 8; i++) seq[1+i] = data[i];
    nb = 9;
    if (has_par) begin
      seq[nb] = par_bit;
      nb = nb + 1;
    end
    seq[nb] = 1'b1;
    nb = nb + 1;
    if (stop2) begin
      seq[nb] = 1'b1;
      nb = nb + 1;
    end
    for (int b = 0; b < nb; b++) begin
      obs = '0;
      exp = '0;
      for (int k = 0; k < bp; k++) begin
        obs[k] = txd_log[p + 1 + b*bp + k];
        exp[k] = seq[b];
      end
      check($sformatf("%s_bit%0d", tag, b), obs, exp);
    end
  endtask

  initial begin
    int p, p1;
    reset       = 1'b1;
    tx_en       = 1'b1;
    baud_div    = 16'd3;
    cfg_stop2   = 1'b0;
    cfg_par_en  = 1'b0;
    cfg_par_odd = 1'b0;
    fifo_sync();

    // Reset state, with data available and tx_en high: no pop allowed.
    push(8'h99);
    repeat (3) tick();
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, 32'd0);
    check("rst_no_pop", pop_cyc.size(), 0);
    tx_en = 1'b0;
    fifo_q.delete();
    fifo_sync();
    reset = 1'b0;
    repeat (2) tick();

    // 0x55, 4-cycle bits, one stop bit: 40 busy cycles.
    pop_cyc.delete();
    baud_div = 16'd3;
    push(8'h55);
    tx_en = 1'b1;
    wait_pop(1, 20, "f55_pop");
    p = pop_at(0);
    repeat (45) tick();
    check_frame("f55", p, 8'h55, 4, 1'b0, 1'b0, 1'b0);
    check("f55_busy_at_pop", {31'd0, busy_log[p]}, 32'd0);
    check("f55_busy_len", busy_count(p, p + 44), 40);
    check("f55_pops", pop_cyc.size(), 1);
    tx_en = 1'b0;

    // 0xA3 with odd parity requested, 2-cycle bits.
    pop_cyc.delete();
    baud_div    = 16'd1;
    cfg_par_en  = 1'b1;
    cfg_par_odd = 1'b1;
    push(8'hA3);
    tx_en = 1'b1;
    wait_pop(1, 20, "fa3_pop");
    p = pop_at(0);
    repeat (30) tick();
`ifdef UART_TX_PARITY_EN
    check_frame("fa3", p, 8'hA3, 2, 1'b0, 1'b1, 1'b1);
    check("fa3_busy_len", busy_count(p, p + 29), 22);
`else
    check_frame("fa3", p, 8'hA3, 2, 1'b0, 1'b0, 1'b0);
    check("fa3_busy_len", busy_count(p, p + 29), 20);
`endif
    tx_en       = 1'b0;
    cfg_par_en  = 1'b0;
    cfg_par_odd = 1'b0;

    // Three queued bytes, 1-cycle bits, two stop bits: back-to-back frames of 11 cycles.
    pop_cyc.delete();
    baud_div  = 16'd0;
    cfg_stop2 = 1'b1;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    tx_en = 1'b1;
    wait_pop(3, 60, "b2b_pop");
    p = pop_at(0);
    repeat (15) tick();
    check("b2b_pops", pop_cyc.size(), 3);
    check("b2b_gap1", pop_at(1) - pop_at(0), 11);
    check("b2b_gap2", pop_at(2) - pop_at(1), 11);
    check_frame("b2b0", pop_at(0), 8'h01, 1, 1'b1, 1'b0, 1'b0);
    check_frame("b2b1", pop_at(1), 8'h02, 1, 1'b1, 1'b0, 1'b0);
    check_frame("b2b2", pop_at(2), 8'h03, 1, 1'b1, 1'b0, 1'b0);
    check("b2b_busy_len", busy_count(p, p + 37), 33);
    tx_en     = 1'b0;
    cfg_stop2 = 1'b0;

    // Reset during data bit 4 of 0x0F aborts the frame.
    pop_cyc.delete();
    baud_div = 16'd3;
    push(8'h0F);
    tx_en = 1'b1;
    wait_pop(1, 20, "rstmid_pop");
    p = pop_at(0);
    while (cyc < p + 22) tick();
    reset = 1'b1;
    tick();
    check("rstmid_in_bit4", {31'd0, txd_log[p + 21]}, 32'd0);
    check("rstmid_txd", {31'd0, txd}, 32'd1);
    check("rstmid_busy", {31'd0, tx_busy}, 32'd0);
    check("rstmid_state", {29'd0, state_dbg}, 32'd0);
    reset = 1'b0;
    repeat (10) tick();
    check("rstmid_no_pop", pop_cyc.size(), 1);
    check("rstmid_idle", busy_count(cyc - 10, cyc - 1), 0);
    tx_en = 1'b0;

    // tx_en dropped during START with two bytes queued.
    pop_cyc.delete();
    baud_div = 16'd1;
    push(8'h11);
    push(8'h22);
    tx_en = 1'b1;
    wait_pop(1, 20, "txen_pop");
    p = pop_at(0);
    tx_en = 1'b0;
    repeat (30) tick();
    check("txen_pops", pop_cyc.size(), 1);
    check("txen_fifo_left", {31'd0, fifo_empty}, 32'd0);
    check_frame("txen", p, 8'h11, 2, 1'b0, 1'b0, 1'b0);
    check("txen_busy_len", busy_count(p, p + 29), 20);
    fifo_q.delete();
    fifo_sync();

    // baud_div changed 3 -> 7 during DATA: applies to the next frame only.
    pop_cyc.delete();
    baud_div = 16'd3;
    push(8'hC5);
    push(8'h3A);
    tx_en = 1'b1;
    wait_pop(1, 20, "div_pop");
    p = pop_at(0);
    while (cyc < p + 8) tick();
    baud_div = 16'd7;
    wait_pop(2, 60, "div_pop2");
    p1 = pop_at(1);
    repeat (90) tick();
    check("div_gap", p1 - p, 40);
    check_frame("div0", p, 8'hC5, 4, 1'b0, 1'b0, 1'b0);
    check_frame("div1", p1, 8'h3A, 8, 1'b0, 1'b0, 1'b0);
    tx_en = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
